poly_horner_mac: RTL and testbench

Parametrised single-MAC polynomial evaluator computing result = Σ coef[k]·x^k for k = 0..deg, using Horner's rule with one multiply-accumulate per cycle. It generalises the fixed quadratic a·x²+b·x+c engine to a run-time degree up to MAX_DEG, configurable widths, a valid/ready handshake on both sides, and an overflow flag. It sits in the arithmetic datapath as a drop-in replacement wherever the fixed quadratic evaluator is used; deg=2 reproduces its function.

---
 rtl/poly_horner_mac.sv | 108 ++++++++++
 tb/tb_poly_horner_mac.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/poly_horner_mac.sv
// Single-MAC polynomial evaluator: result = sum(coef[k] * x^k), k = 0..deg, by Horner's rule.
// One multiply-accumulate per enabled cycle; valid/ready on both sides; sticky per-job overflow.
module poly_horner_mac #(
  parameter int DATA_W  = 8,
  parameter int MAX_DEG = 4,
  parameter int RES_W   = 16,
  localparam int DEG_W  = $clog2(MAX_DEG + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_x,
  input  logic [DEG_W-1:0]              in_deg,
  input  logic [(MAX_DEG+1)*DATA_W-1:0] in_coef,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [RES_W-1:0]              result,
  output logic                          overflow
);

  localparam int FULL_W = RES_W + DATA_W + 1;
  localparam logic [DEG_W-1:0] MAX_DEG_D = DEG_W'(MAX_DEG);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [RES_W-1:0]  acc;
  logic [DEG_W-1:0]  cnt;
  logic [DEG_W-1:0]  cnt_m1;
  logic [DATA_W-1:0] x_r;
  logic [DATA_W-1:0] coef_r  [MAX_DEG+1];
  logic [DATA_W-1:0] coef_in [MAX_DEG+1];
  logic              ovf_acc;

  logic [DEG_W-1:0]  deg_clamp;
  logic [DATA_W-1:0] coef_top;
  logic              accept;
  logic [FULL_W-1:0] mac_full;
  logic [RES_W-1:0]  mac_res;
  logic              mac_ovf;

  for (genvar k = 0; k <= MAX_DEG; k++) begin : g_unpack
    assign coef_in[k] = in_coef[k*DATA_W +: DATA_W];
  end

  assign in_ready  = enable & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == S_DONE);

  assign deg_clamp = (in_deg > MAX_DEG_D) ? MAX_DEG_D : in_deg;
  assign coef_top  = coef_in[deg_clamp];
  assign cnt_m1    = cnt - DEG_W'(1);

  // Full-precision step: the sum cannot exceed FULL_W bits, so any set bit above RES_W is a true overflow.
  assign mac_full = FULL_W'(acc) * FULL_W'(x_r) + FULL_W'(coef_r[cnt_m1]);
  assign mac_res  = mac_full[RES_W-1:0];
  assign mac_ovf  = |mac_full[FULL_W-1:RES_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      acc      <= '0;
      cnt      <= '0;
      x_r      <= '0;
      ovf_acc  <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      for (int k = 0; k <= MAX_DEG; k++) coef_r[k] <= '0;
    end else if (enable) begin
      if (accept) begin
        x_r     <= in_x;
        acc     <= RES_W'(coef_top);
        cnt     <= deg_clamp;
        ovf_acc <= 1'b0;
        for (int k = 0; k <= MAX_DEG; k++) coef_r[k] <= coef_in[k];
        if (deg_clamp == '0) begin
          state    <= S_DONE;
          result   <= RES_W'(coef_in[0]);
          overflow <= 1'b0;
        end else begin
          state <= S_MAC;
        end
      end else begin
        case (state)
          S_MAC: begin
            acc     <= mac_res;
            ovf_acc <= ovf_acc | mac_ovf;
            cnt     <= cnt_m1;
            if (cnt == DEG_W'(1)) begin
              state    <= S_DONE;
              result   <= mac_res;
              overflow <= ovf_acc | mac_ovf;
            end
          end
          S_DONE: begin
            if (out_ready) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_poly_horner_mac.sv
// Directed bench for poly_horner_mac: table-driven jobs plus hand-written handshake,
// enable-stall, backpressure and mid-job reset sequences.
module tb_poly_horner_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [2:0]  in_deg;
  logic [39:0] in_coef;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  poly_horner_mac #(.DATA_W(8), .MAX_DEG(4), .RES_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_deg(in_deg), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  x;
    logic [2:0]  deg;
    logic [39:0] coef;
    logic [15:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [39:0] pack(input logic [7:0] c0, c1, c2, c3, c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic start_job(input logic [7:0] x, input logic [2:0] d, input logic [39:0] c);
    bit ok = 0;
    in_x = x; in_deg = d; in_coef = c; in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (in_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("accept_timeout", {31'd0, ok}, 32'd1);
    if (ok) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Latency counted in clock edges including the accept edge.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;

  initial begin
    vecs[0]  = '{8'd8,   3'd2, pack(7, 13, 5, 0, 0),         16'd431,   1'b0, 3};
    vecs[1]  = '{8'd0,   3'd2, pack(3, 2, 1, 0, 0),          16'd3,     1'b0, 3};
    vecs[2]  = '{8'd4,   3'd2, pack(10, 18, 25, 0, 0),       16'd482,   1'b0, 3};
    vecs[3]  = '{8'd5,   3'd0, pack(9, 3, 3, 3, 3),          16'd9,     1'b0, 1};
    vecs[4]  = '{8'd2,   3'd7, pack(1, 1, 1, 1, 1),          16'd31,    1'b0, 5};
    vecs[5]  = '{8'd255, 3'd4, pack(255, 255, 255, 255, 255), 16'd767,  1'b1, 5};
    vecs[6]  = '{8'd2,   3'd1, pack(1, 1, 0, 0, 0),          16'd3,     1'b0, 2};
    vecs[7]  = '{8'd3,   3'd3, pack(1, 2, 3, 4, 0),          16'd142,   1'b0, 4};
    vecs[8]  = '{8'd255, 3'd1, pack(255, 255, 0, 0, 0),      16'd65280, 1'b0, 2};
    vecs[9]  = '{8'd255, 3'd2, pack(0, 0, 255, 0, 0),        16'd767,   1'b1, 3};
    vecs[10] = '{8'd1,   3'd4, pack(1, 2, 3, 4, 5),          16'd15,    1'b0, 5};
    vecs[11] = '{8'd16,  3'd3, pack(0, 0, 0, 16, 0),         16'd0,     1'b1, 4};

    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_x = '0; in_deg = '0; in_coef = '0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", {16'd0, result}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Table of independent jobs with out_ready held high
    for (int i = 0; i < 12; i++) begin
      start_job(vecs[i].x, vecs[i].deg, vecs[i].coef);
      wait_done(lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_result", i), {16'd0, result}, {16'd0, vecs[i].res});
      check($sformatf("vec%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].ovf});
      @(negedge clk);
      check($sformatf("vec%0d_released", i), {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back: each DONE transfer coincides with the next accept
    start_job(8'd8, 3'd2, pack(7, 13, 5, 0, 0));
    wait_done(lat);
    check("b2b0_result", {16'd0, result}, 32'd431);
    in_x = 8'd0; in_deg = 3'd2; in_coef = pack(3, 2, 1, 0, 0); in_valid = 1'b1;
    #1 check("b2b1_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    check("b2b1_latency", lat, 3);
    check("b2b1_result", {16'd0, result}, 32'd3);
    in_x = 8'd4; in_deg = 3'd2; in_coef = pack(10, 18, 25, 0, 0); in_valid = 1'b1;
    #1 check("b2b2_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    check("b2b2_latency", lat, 3);
    check("b2b2_result", {16'd0, result}, 32'd482);
    @(negedge clk);

    // enable=0 for two cycles mid-MAC, then frozen in DONE with both handshakes requested
    start_job(8'd4, 3'd2, pack(10, 18, 25, 0, 0));
    enable = 1'b0; in_valid = 1'b1; in_coef = pack(1, 1, 1, 1, 1);
    #1 check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("stall_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    enable = 1'b1; in_valid = 1'b0;
    lat = 3;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("stall_latency", lat, 5);
    check("stall_result", {16'd0, result}, 32'd482);
    enable = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("freeze_out_valid", {31'd0, out_valid}, 32'd1);
    check("freeze_result", {16'd0, result}, 32'd482);
    check("freeze_in_ready", {31'd0, in_ready}, 32'd0);
    enable = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("unfreeze_transfer", {31'd0, out_valid}, 32'd0);

    // Backpressure in DONE for 5 cycles; inputs changed mid-job must not matter
    start_job(8'd8, 3'd2, pack(7, 13, 5, 0, 0));
    in_x = 8'd99; in_coef = pack(200, 200, 200, 200, 200);
    wait_done(lat);
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      check($sformatf("bp%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp%0d_result", i), {16'd0, result}, 32'd431);
      check($sformatf("bp%0d_overflow", i), {31'd0, overflow}, 32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("bp_transfer", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of a degree-4 job
    start_job(8'd255, 3'd4, pack(255, 255, 255, 255, 255));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_result", {16'd0, result}, 32'd0);
    check("abort_overflow", {31'd0, overflow}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (6) @(negedge clk);
    check("abort_no_result", {31'd0, out_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    start_job(8'd8, 3'd2, pack(7, 13, 5, 0, 0));
    wait_done(lat);
    check("post_reset_latency", lat, 3);
    check("post_reset_result", {16'd0, result}, 32'd431);
    check("post_reset_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
